// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit_pkg
// Brief    : Shared constants, IF/ID record type and alignment helper for the
//            IF stage of the P5 pipelined MIPS core.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pc_unit_pkg;

    // Reset fetch address (MARS text base) and the bubble instruction word
    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

    // Opcodes / functs of the instructions that produce a next-PC redirect
    localparam logic [5:0] JUMP_OP_SPECIAL = 6'h00;
    localparam logic [5:0] JUMP_OP_J       = 6'h02;
    localparam logic [5:0] JUMP_OP_JAL     = 6'h03;
    localparam logic [5:0] JUMP_OP_BEQ     = 6'h04;
    localparam logic [5:0] JUMP_OP_BNE     = 6'h05;
    localparam logic [5:0] JUMP_FUNCT_JR   = 6'h08;
    localparam logic [5:0] JUMP_FUNCT_JALR = 6'h09;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    // Fetch addresses are always word aligned
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit_if
// Brief    : Redirect, instruction-memory and IF/ID signals of the fetch unit.
//            master = fetch unit, slave = ID stage / memory / environment.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_pc_unit_if;

    logic        stall;
    logic        redirect_sel;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;

    modport master (
        input  stall, redirect_sel, redirect_target, imem_rdata,
        output imem_addr, id_instr, id_pc, id_pc4, id_valid
    );

    modport slave (
        output stall, redirect_sel, redirect_target, imem_rdata,
        input  imem_addr, id_instr, id_pc, id_pc4, id_valid
    );

endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit_redirect_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_buf
// Brief    : Holds a redirect that arrived while stalled and selects the next
//            fetch PC (live redirect > pending redirect > sequential PC+4).
// Revision : 1.0  initial release
// ============================================================================
module fetch_redirect_buf
    import fetch_pc_unit_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        capture_i,
    input  wire logic        clear_i,
    input  wire logic        redirect_sel_i,
    input  wire logic [31:0] redirect_target_i,
    input  wire logic [31:0] pc_plus4_i,
    output logic      [31:0] next_pc_o,
    output logic             redirect_apply_o
);

    logic        pend_valid_q;
    logic [31:0] pend_target_q;

    // Pending buffer: a later capture in the same stall overwrites the earlier one
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else if (capture_i) begin
            pend_valid_q  <= 1'b1;
            pend_target_q <= word_align(redirect_target_i);
        end else if (clear_i) begin
            pend_valid_q  <= 1'b0;
        end
    end

    // Next-PC priority mux; a live redirect drops any pending one
    always_comb begin
        next_pc_o        = pc_plus4_i;
        redirect_apply_o = 1'b0;
        if (redirect_sel_i) begin
            next_pc_o        = word_align(redirect_target_i);
            redirect_apply_o = 1'b1;
        end else if (pend_valid_q) begin
            next_pc_o        = pend_target_q;
            redirect_apply_o = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Brief    : IF-stage PC register and IF/ID pipeline register. Drives the
//            instruction-memory address and hands fetched words to ID.
//            Build option FETCH_DELAY_SLOT_EN: keep the word fetched in the
//            redirect cycle (branch delay slot); otherwise it is squashed.
// Revision : 1.0  initial release
// ============================================================================
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_ADDR,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
)(
    input  wire logic             clk,
    input  wire logic             reset,
    fetch_pc_unit_if.master       bus
);

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit SQUASH_EN = 1'b0;
`else
    localparam bit SQUASH_EN = 1'b1;
`endif

    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_redirect_apply;
    logic        w_squash;

    assign w_pc_plus4 = pc_q + 32'd4;
    assign w_squash   = SQUASH_EN & w_redirect_apply;

    fetch_redirect_buf u_redirect_buf (
        .clk               (clk),
        .reset             (reset),
        .capture_i         (bus.stall & bus.redirect_sel),
        .clear_i           (~bus.stall),
        .redirect_sel_i    (bus.redirect_sel),
        .redirect_target_i (bus.redirect_target),
        .pc_plus4_i        (w_pc_plus4),
        .next_pc_o         (w_next_pc),
        .redirect_apply_o  (w_redirect_apply)
    );

    // Next PC and IF/ID contents; everything holds while stalled
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (!bus.stall) begin
            pc_d       = w_next_pc;
            ifid_d.pc  = pc_q;
            ifid_d.pc4 = w_pc_plus4;
            if (w_squash) begin
                ifid_d.instr = NOP_INSTR;
                ifid_d.valid = 1'b0;
            end else begin
                ifid_d.instr = bus.imem_rdata;
                ifid_d.valid = 1'b1;
            end
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= PC_RESET;
            ifid_q <= '{instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0, valid: 1'b0};
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.id_instr  = ifid_q.instr;
    assign bus.id_pc     = ifid_q.pc;
    assign bus.id_pc4    = ifid_q.pc4;
    assign bus.id_valid  = ifid_q.valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_unit
// Brief    : Self-checking bench for fetch_pc_unit (reference model feeding a
//            scoreboard, plus directed checks of the key scenarios).
//            Honours FETCH_DELAY_SLOT_EN the same way as the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_pc_unit;

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit SQUASH = 1'b0;
`else
    localparam bit SQUASH = 1'b1;
`endif
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    logic clk;
    logic reset;
    fetch_pc_unit_if bus ();

    fetch_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Combinational ROM with an address-dependent, nonzero pattern
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction
    assign bus.imem_rdata = rom(bus.imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // Reference model state
    logic [31:0] m_pc, m_pt, m_instr, m_idpc, m_idpc4;
    logic        m_pv, m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, push expectation, compare after the edge
    task automatic step(input logic st, input logic rs, input logic [31:0] rt, input logic rst);
        exp_t        e;
        logic [31:0] np;
        logic        redir;
        @(negedge clk);
        bus.stall           = st;
        bus.redirect_sel    = rs;
        bus.redirect_target = rt;
        reset               = rst;
        if (rst) begin
            m_pc = RST_PC; m_instr = NOP; m_idpc = 0; m_idpc4 = 0; m_valid = 0; m_pv = 0; m_pt = 0;
        end else if (st) begin
            if (rs) begin
                m_pv = 1'b1;
                m_pt = rt & 32'hFFFF_FFFC;
            end
        end else begin
            redir   = rs | m_pv;
            np      = rs ? (rt & 32'hFFFF_FFFC) : (m_pv ? m_pt : m_pc + 32'd4);
            m_idpc  = m_pc;
            m_idpc4 = m_pc + 32'd4;
            if (SQUASH && redir) begin
                m_instr = NOP;
                m_valid = 1'b0;
            end else begin
                m_instr = rom(m_pc);
                m_valid = 1'b1;
            end
            m_pc = np;
            m_pv = 1'b0;
        end
        sb_q.push_back('{addr: m_pc, instr: m_instr, pc: m_idpc, pc4: m_idpc4, valid: m_valid});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("imem_addr", bus.imem_addr, e.addr);
        chk("id_instr",  bus.id_instr,  e.instr);
        chk("id_pc",     bus.id_pc,     e.pc);
        chk("id_pc4",    bus.id_pc4,    e.pc4);
        chk("id_valid",  {31'h0, bus.id_valid}, {31'h0, e.valid});
    endtask

    initial begin
        bus.stall = 0; bus.redirect_sel = 0; bus.redirect_target = 0; reset = 1;
        m_pc = 0; m_pt = 0; m_pv = 0; m_instr = 0; m_idpc = 0; m_idpc4 = 0; m_valid = 0;

        // 1. reset two cycles, then sequential fetch
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("t1_rst_addr",  bus.imem_addr, 32'h3000);
        chk("t1_rst_valid", {31'h0, bus.id_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("t1_addr_3004", bus.imem_addr, 32'h3004);
        chk("t1_idpc_3000", bus.id_pc, 32'h3000);
        chk("t1_valid",     {31'h0, bus.id_valid}, 32'h1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t1_addr_300c", bus.imem_addr, 32'h300C);

        // 2. redirect at 300C to 3040
        step(0, 1, 32'h3040, 0);
        chk("t2_addr",  bus.imem_addr, 32'h3040);
        chk("t2_id_pc", bus.id_pc, 32'h300C);
`ifdef FETCH_DELAY_SLOT_EN
        chk("t2_valid", {31'h0, bus.id_valid}, 32'h1);
`else
        chk("t2_valid", {31'h0, bus.id_valid}, 32'h0);
        chk("t2_instr", bus.id_instr, 32'h0);
`endif

        // 3. reach 3010, stall 3 cycles with a redirect to 3100 in the first
        step(0, 1, 32'h3010, 0);
        step(0, 0, 0, 0);
        chk("t3_addr_3014", bus.imem_addr, 32'h3014);
        step(0, 1, 32'h3010, 0);
        step(1, 1, 32'h3100, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("t3_hold", bus.imem_addr, 32'h3010);
        step(0, 0, 0, 0);
        chk("t3_release", bus.imem_addr, 32'h3100);
        step(0, 0, 0, 0);
        chk("t3_pend_clr", bus.imem_addr, 32'h3104);

        // 4. two redirects under stall, then live redirect on release wins
        step(1, 1, 32'h3100, 0);
        step(1, 1, 32'h3200, 0);
        step(0, 1, 32'h3300, 0);
        chk("t4_live", bus.imem_addr, 32'h3300);
        step(0, 0, 0, 0);
        chk("t4_seq", bus.imem_addr, 32'h3304);

        // 4b. overwrite under stall, release without live redirect
        step(1, 1, 32'h3100, 0);
        step(1, 1, 32'h3200, 0);
        step(0, 0, 0, 0);
        chk("t4_overwrite", bus.imem_addr, 32'h3200);

        // 5. alignment and wrap
        step(0, 1, 32'h0000_3043, 0);
        chk("t5_align", bus.imem_addr, 32'h3040);
        step(0, 1, 32'hFFFF_FFFF, 0);
        chk("t5_top", bus.imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("t5_wrap", bus.imem_addr, 32'h0);
        chk("t5_wrap_pc4", bus.id_pc4, 32'h0);
        step(0, 0, 0, 0);

        // 6. reset during stall with a pending redirect
        step(1, 1, 32'h3500, 0);
        step(1, 0, 0, 1);
        chk("t6_rst_addr",  bus.imem_addr, 32'h3000);
        chk("t6_rst_valid", {31'h0, bus.id_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("t6_no_pend", bus.imem_addr, 32'h3004);
        step(0, 0, 0, 0);
        chk("t6_seq", bus.imem_addr, 32'h3008);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
